// File: rtl/mdu_hilo.sv
// mdu_hilo: EXE-stage multiply/divide unit with architectural HI/LO registers.
// A launch latches the operands and holds Busy for a fixed number of cycles.
// The result is computed from the latched operands and commits to HI/LO on the
// edge that ends the last Busy cycle. mthi/mtlo write HI/LO in a single cycle.
module mdu_hilo #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MD_Op,
  input  logic        Flush,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_count;
  md_op_e          r_op;
  logic [31:0]     r_a, r_b;
  logic [31:0]     r_hi, r_lo;

  md_op_e          w_op;
  logic            w_is_md;
  logic            w_launch;
  logic            w_commit;
  logic            w_mt_hi, w_mt_lo;
  logic [CW-1:0]   w_lat;

  logic [63:0]     w_prod_s, w_prod_u;
  logic            w_div_signed;
  logic [31:0]     w_mag_a, w_mag_b, w_div_b;
  logic [31:0]     w_q_mag, w_r_mag, w_quot, w_rem;
  logic [31:0]     w_res_hi, w_res_lo;
  logic            w_res_we;

  assign w_op     = md_op_e'(MD_Op);
  assign w_is_md  = (w_op == OP_MULT) || (w_op == OP_MULTU) ||
                    (w_op == OP_DIV)  || (w_op == OP_DIVU);
  assign Busy     = (r_count != '0);
  assign w_launch = Start && w_is_md && !Flush && !Busy;
  // The last Busy cycle is the one with counter==1; its closing edge commits.
  assign w_commit = (r_state == S_RUN) && (r_count == CW'(1));
  // mthi/mtlo ignore Start; while Busy they are dropped so the in-flight op wins.
  assign w_mt_hi  = (w_op == OP_MTHI) && !Flush && !Busy;
  assign w_mt_lo  = (w_op == OP_MTLO) && !Flush && !Busy;
  assign w_lat    = ((w_op == OP_DIV) || (w_op == OP_DIVU)) ? CW'(DIV_LAT) : CW'(MULT_LAT);
  assign HI       = r_hi;
  assign LO       = r_lo;

  // Products: sign/zero extend to 64 bits so the low 64 bits of the product are exact.
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide on magnitudes, then restore signs. This keeps the
  // 0x80000000 / -1 case well defined (quotient wraps to 0x80000000).
  assign w_div_signed = (r_op == OP_DIV);
  assign w_mag_a = (w_div_signed && r_a[31]) ? (~r_a + 32'd1) : r_a;
  assign w_mag_b = (w_div_signed && r_b[31]) ? (~r_b + 32'd1) : r_b;
  // Divisor forced to 1 when zero only to keep the divider defined; the result is discarded.
  assign w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_q_mag = w_mag_a / w_div_b;
  assign w_r_mag = w_mag_a % w_div_b;
  assign w_quot  = (w_div_signed && (r_a[31] ^ r_b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem   = (w_div_signed && r_a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

  // Select the result of the in-flight operation and whether it may be written.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    w_res_we = 1'b0;
    case (r_op)
      OP_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        w_res_we = 1'b1;
      end
      OP_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
        w_res_we = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        w_res_hi = w_rem;
        w_res_lo = w_quot;
        w_res_we = (r_b != 32'd0);
      end
      default: ;
    endcase
  end

  // Next-state logic: IDLE->RUN on an accepted launch, RUN->IDLE on the commit edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (w_commit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Operand latch and Busy counter: load on launch, count down to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_op    <= OP_NONE;
      r_a     <= '0;
      r_b     <= '0;
    end else if (w_launch) begin
      r_count <= w_lat;
      r_op    <= w_op;
      r_a     <= A;
      r_b     <= B;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Architectural HI/LO: commit of an in-flight op, or a single-cycle mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (w_res_we) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end else begin
      if (w_mt_hi) r_hi <= A;
      if (w_mt_lo) r_lo <= A;
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed stimulus with a scoreboard queue. The stimulus process
// pushes the expected HI/LO and Busy length per launch; a monitor pops and
// compares whenever Busy falls, and checks HI/LO hold their old value while Busy.
module tb_mdu_hilo;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MD_Op;
  logic        Flush;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks, n_errors;

  mdu_hilo #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MD_Op (MD_Op),
    .Flush (Flush),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for the next rising edge, then drive all inputs just after it.
  task automatic drive(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
    @(posedge clk);
    #1;
    Start = st;
    MD_Op = op;
    A     = a;
    B     = b;
    Flush = fl;
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int lat);
    exp_t e;
    e.hi     = hi;
    e.lo     = lo;
    e.old_hi = m_hi;
    e.old_lo = m_lo;
    e.lat    = lat;
    sb_q.push_back(e);
    m_hi = hi;
    m_lo = lo;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!Busy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'(Busy), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int lat);
    drive(1'b1, op, a, b, 1'b0);
    push(hi, lo, lat);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    wait_idle();
    check("post_hi", HI, m_hi);
    check("post_lo", LO, m_lo);
  endtask

  // mthi then mtlo on consecutive cycles; each becomes visible one cycle after issue.
  task automatic mt_pair(input logic [31:0] hv, input logic [31:0] lv);
    drive(1'b0, 3'd5, hv, 32'd0, 1'b0);
    drive(1'b0, 3'd6, lv, 32'd0, 1'b0);
    @(negedge clk);
    check("mthi_hi", HI, hv);
    check("mthi_lo_hold", LO, m_lo);
    check("mthi_busy", 32'(Busy), 32'd0);
    m_hi = hv;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("mtlo_lo", LO, lv);
    check("mtlo_hi_hold", HI, m_hi);
    check("mtlo_busy", 32'(Busy), 32'd0);
    m_lo = lv;
  endtask

  // Monitor: hold checks while Busy, commit checks when Busy falls.
  initial begin
    logic prev_busy, prev_reset;
    int   busy_cnt;
    exp_t e;
    prev_busy  = 1'b0;
    prev_reset = 1'b0;
    busy_cnt   = 0;
    forever begin
      @(negedge clk);
      if (Busy) begin
        busy_cnt++;
        if (sb_q.size() == 0) begin
          check("busy_unexpected", 32'(Busy), 32'd0);
        end else begin
          check("hold_hi", HI, sb_q[0].old_hi);
          check("hold_lo", LO, sb_q[0].old_lo);
        end
      end else if (prev_busy) begin
        if (prev_reset) begin
          if (sb_q.size() > 0) e = sb_q.pop_front();
        end else if (sb_q.size() == 0) begin
          check("commit_unexpected", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("busy_len", 32'(busy_cnt), 32'(e.lat));
          check("commit_hi", HI, e.hi);
          check("commit_lo", LO, e.lo);
        end
        busy_cnt = 0;
      end
      prev_busy  = Busy;
      prev_reset = reset;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    reset = 1'b1;
    Start = 1'b0;
    MD_Op = 3'd0;
    Flush = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    // Basic arithmetic.
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);

    // Divide by zero leaves HI/LO untouched.
    mt_pair(32'h1111_1111, 32'h1111_1111);
    run_op(3'd4, 32'd7, 32'd0, 32'h1111_1111, 32'h1111_1111, 10);

    mt_pair(32'h1234_5678, 32'h9ABC_DEF0);

    // Second Start while Busy is ignored.
    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    push(32'd2, 32'd14, 10);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 3'd1, 32'd3, 32'd3, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    wait_idle();
    check("viol_hi", HI, 32'd2);
    check("viol_lo", LO, 32'd14);

    // Flush suppresses both a launch and an mt write.
    drive(1'b1, 3'd1, 32'd5, 32'd5, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("flush_busy", 32'(Busy), 32'd0);
    check("flush_hi", HI, m_hi);
    check("flush_lo", LO, m_lo);
    drive(1'b0, 3'd5, 32'hAAAA_5555, 32'd0, 1'b1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("flush_mthi", HI, m_hi);

    // Signed corner cases.
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);

    // mthi during Busy is dropped.
    drive(1'b1, 3'd2, 32'd3, 32'd4, 1'b0);
    push(32'd0, 32'd12, 5);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    wait_idle();
    check("mt_busy_hi", HI, 32'd0);
    check("mt_busy_lo", LO, 32'd12);

    // Reset in the third Busy cycle of a div discards the result.
    drive(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
    push(32'd2, 32'd14, 10);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_late_busy", 32'(Busy), 32'd0);
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);
    check("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
